flash_fetch_arbiter: RTL and testbench

Sequences the single read port of the 1K x 16 program-flash BRAM and shares it between two requesters: the core's instruction-fetch unit (IF) and the LPM data path, which reads bytes through the Z pointer. The block drives the BRAM read enable and address, tracks which requester owns each in-flight read, and returns data with a valid pulse. Fetch words are held in a register, and LPM reads get byte-lane selection. It sits between the core pipeline and the flash BRAM.

---
 rtl/flash_pkg.sv | 20 ++
 rtl/flash_rr_arb2.sv | 37 +++
 rtl/flash_fetch_arbiter.sv | 123 ++++++++++++
 tb/tb_flash_fetch_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_pkg.sv
// Shared widths, read-latency constant and the in-flight read tag for the flash fetch arbiter.
// FLASH_DO_REG_EN selects the BRAM output-register build (read latency 2).
package flash_pkg;

    localparam int FLASH_ADDR_W = 10;
    localparam int FLASH_DATA_W = 16;

`ifdef FLASH_DO_REG_EN
    localparam int FLASH_RD_LAT = 2;
`else
    localparam int FLASH_RD_LAT = 1;
`endif

    typedef struct packed {
        logic is_if;
        logic is_lpm;
        logic lsb;
    } rd_tag_t;

endpackage

// File: rtl/flash_rr_arb2.sv
// Two-way round-robin grant between instruction fetch and LPM.
// The pointer only moves on contended cycles; after reset LPM wins the first contention.
module flash_rr_arb2 (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_req_if,
    input  logic i_req_lpm,
    output logic o_gnt_if,
    output logic o_gnt_lpm
);

    logic r_last_lpm;
    logic w_contend;

    assign w_contend = i_req_if & i_req_lpm;

    always_comb begin
        o_gnt_if  = 1'b0;
        o_gnt_lpm = 1'b0;
        if (w_contend) begin
            o_gnt_lpm = ~r_last_lpm;
            o_gnt_if  = r_last_lpm;
        end else begin
            o_gnt_if  = i_req_if;
            o_gnt_lpm = i_req_lpm;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_lpm <= 1'b0;
        end else if (w_contend) begin
            r_last_lpm <= o_gnt_lpm;
        end
    end

endmodule

// File: rtl/flash_fetch_arbiter.sv
// Shares the program-flash BRAM read port between instruction fetch and LPM byte reads.
// Define FLASH_DO_REG_EN when the BRAM output register is enabled (adds a second tag stage).
module flash_fetch_arbiter
    import flash_pkg::*;
#(
    parameter int ADDR_W = FLASH_ADDR_W,
    parameter int DATA_W = FLASH_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_gnt,
    input  logic              i_if_flush,
    output logic              o_if_vld,
    output logic [DATA_W-1:0] o_if_data,
    input  logic              i_lpm_req,
    input  logic [ADDR_W:0]   i_lpm_addr,
    output logic              o_lpm_gnt,
    output logic              o_lpm_vld,
    output logic [7:0]        o_lpm_data,
    output logic              o_mem_rden,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_regce,
    output logic              o_mem_rst,
    input  logic [DATA_W-1:0] i_mem_do
);

    logic              w_if_gnt;
    logic              w_lpm_gnt;
    rd_tag_t           w_s1_next;
    rd_tag_t           r_s1;
    rd_tag_t           w_tag_out;
    logic              w_if_vld;
    logic              w_lpm_vld;
    logic [7:0]        w_lpm_byte;
    logic [DATA_W-1:0] r_if_hold;
    logic [7:0]        r_lpm_hold;

    // Requests are masked during reset so no grant or BRAM access leaks out.
    flash_rr_arb2 u_arb (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_req_if  (i_if_req & i_rst_n),
        .i_req_lpm (i_lpm_req & i_rst_n),
        .o_gnt_if  (w_if_gnt),
        .o_gnt_lpm (w_lpm_gnt)
    );

    always_comb begin
        o_mem_addr = '0;
        if (w_if_gnt) begin
            o_mem_addr = i_if_addr;
        end else if (w_lpm_gnt) begin
            o_mem_addr = i_lpm_addr[ADDR_W:1];
        end
    end

    // A fetch granted in the flush cycle is the redirect target, so it is tagged normally.
    always_comb begin
        w_s1_next        = '0;
        w_s1_next.is_if  = w_if_gnt;
        w_s1_next.is_lpm = w_lpm_gnt;
        w_s1_next.lsb    = w_lpm_gnt & i_lpm_addr[0];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= '0;
        end else begin
            r_s1 <= w_s1_next;
        end
    end

`ifdef FLASH_DO_REG_EN
    rd_tag_t r_s2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s2 <= '0;
        end else begin
            r_s2.is_if  <= r_s1.is_if & ~i_if_flush;
            r_s2.is_lpm <= r_s1.is_lpm;
            r_s2.lsb    <= r_s1.lsb;
        end
    end

    assign o_mem_regce = r_s1.is_if | r_s1.is_lpm;
    assign w_tag_out   = r_s2;
`else
    assign o_mem_regce = 1'b0;
    assign w_tag_out   = r_s1;
`endif

    assign w_if_vld   = w_tag_out.is_if & ~i_if_flush;
    assign w_lpm_vld  = w_tag_out.is_lpm;
    assign w_lpm_byte = w_tag_out.lsb ? i_mem_do[15:8] : i_mem_do[7:0];

    // The BRAM output is overwritten by the other requester, so each side keeps its last result.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_if_hold  <= '0;
            r_lpm_hold <= '0;
        end else begin
            if (w_if_vld) begin
                r_if_hold <= i_mem_do;
            end
            if (w_lpm_vld) begin
                r_lpm_hold <= w_lpm_byte;
            end
        end
    end

    assign o_if_gnt   = w_if_gnt;
    assign o_lpm_gnt  = w_lpm_gnt;
    assign o_mem_rden = w_if_gnt | w_lpm_gnt;
    assign o_mem_rst  = ~i_rst_n;
    assign o_if_vld   = w_if_vld;
    assign o_lpm_vld  = w_lpm_vld;
    assign o_if_data  = w_if_vld ? i_mem_do : r_if_hold;
    assign o_lpm_data = w_lpm_vld ? w_lpm_byte : r_lpm_hold;

endmodule

// File: tb/tb_flash_fetch_arbiter.sv
// Directed bench for flash_fetch_arbiter with a BRAM model and a response-queue reference model.
// Build with FLASH_DO_REG_EN defined to exercise the output-register variant.
`timescale 1ns/1ps
module tb_flash_fetch_arbiter;
    import flash_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ifReq = 1'b0;
    logic [9:0]  ifAddr = '0;
    logic        ifFlush = 1'b0;
    logic        lpmReq = 1'b0;
    logic [10:0] lpmAddr = '0;

    logic        ifGnt, ifVld, lpmGnt, lpmVld, memRden, memRegce, memRst;
    logic [15:0] ifData;
    logic [7:0]  lpmData;
    logic [9:0]  memAddr;
    logic [15:0] memDo;

    logic [15:0] flashMem [0:1023];
    logic [15:0] memDo1 = '0;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    flash_fetch_arbiter dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_if_req   (ifReq),
        .i_if_addr  (ifAddr),
        .o_if_gnt   (ifGnt),
        .i_if_flush (ifFlush),
        .o_if_vld   (ifVld),
        .o_if_data  (ifData),
        .i_lpm_req  (lpmReq),
        .i_lpm_addr (lpmAddr),
        .o_lpm_gnt  (lpmGnt),
        .o_lpm_vld  (lpmVld),
        .o_lpm_data (lpmData),
        .o_mem_rden (memRden),
        .o_mem_addr (memAddr),
        .o_mem_regce(memRegce),
        .o_mem_rst  (memRst),
        .i_mem_do   (memDo)
    );

    always @(posedge clk) begin
        if (memRst)       memDo1 <= '0;
        else if (memRden) memDo1 <= flashMem[memAddr];
    end

`ifdef FLASH_DO_REG_EN
    logic [15:0] memDo2 = '0;
    always @(posedge clk) begin
        if (memRst)        memDo2 <= '0;
        else if (memRegce) memDo2 <= memDo1;
    end
    assign memDo = memDo2;
`else
    assign memDo = memDo1;
`endif

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: every granted read becomes a pending response due FLASH_RD_LAT cycles later.
    typedef struct {
        int         due;
        int         grant;
        bit         isIf;
        logic [9:0] addr;
        bit         lsb;
    } pendRd_t;

    pendRd_t     pending[$];
    pendRd_t     rd;
    int          cyc = 0;
    int          lastFlush = -100;
    bit          favorIf = 1'b0;
    bit          prevGrant = 1'b0;
    bit          eIf, eLpm, eIfVld, eLpmVld;
    logic [9:0]  eAddr;
    logic [15:0] ifHoldM = '0;
    logic [7:0]  lpmHoldM = '0;
    logic [15:0] word;

    always @(negedge clk) begin
        if (!rst_n) begin
            checkOutput("rstIfGnt", ifGnt, 0);
            checkOutput("rstLpmGnt", lpmGnt, 0);
            checkOutput("rstRden", memRden, 0);
            checkOutput("rstAddr", memAddr, 0);
            checkOutput("rstIfVld", ifVld, 0);
            checkOutput("rstLpmVld", lpmVld, 0);
            checkOutput("rstIfData", ifData, 0);
            checkOutput("rstLpmData", lpmData, 0);
            checkOutput("rstRegce", memRegce, 0);
            checkOutput("rstMemRst", memRst, 1);
            pending.delete();
            favorIf   = 1'b0;
            prevGrant = 1'b0;
            lastFlush = -100;
            ifHoldM   = '0;
            lpmHoldM  = '0;
        end else begin
            cyc++;
            if (ifReq && lpmReq) begin
                eLpm    = !favorIf;
                eIf     = favorIf;
                favorIf = eLpm;
            end else begin
                eIf  = ifReq;
                eLpm = lpmReq;
            end
            eAddr = eIf ? ifAddr : (eLpm ? lpmAddr[10:1] : 10'd0);
            checkOutput("ifGnt", ifGnt, eIf);
            checkOutput("lpmGnt", lpmGnt, eLpm);
            checkOutput("memRden", memRden, eIf | eLpm);
            checkOutput("memAddr", memAddr, eAddr);
            checkOutput("memRst", memRst, 0);

            if (ifFlush) lastFlush = cyc;
            eIfVld  = 1'b0;
            eLpmVld = 1'b0;
            if (pending.size() > 0 && pending[0].due == cyc) begin
                rd = pending.pop_front();
                word = flashMem[rd.addr];
                if (rd.isIf) begin
                    if (lastFlush <= rd.grant) begin
                        eIfVld  = 1'b1;
                        ifHoldM = word;
                    end
                end else begin
                    eLpmVld  = 1'b1;
                    lpmHoldM = rd.lsb ? word[15:8] : word[7:0];
                end
            end
            checkOutput("ifVld", ifVld, eIfVld);
            checkOutput("lpmVld", lpmVld, eLpmVld);
            checkOutput("ifData", ifData, ifHoldM);
            checkOutput("lpmData", lpmData, lpmHoldM);
`ifdef FLASH_DO_REG_EN
            checkOutput("memRegce", memRegce, prevGrant);
`else
            checkOutput("memRegce", memRegce, 0);
`endif
            prevGrant = eIf | eLpm;
            if (eIf || eLpm) begin
                rd.due   = cyc + FLASH_RD_LAT;
                rd.grant = cyc;
                rd.isIf  = eIf;
                rd.addr  = eAddr;
                rd.lsb   = eLpm & lpmAddr[0];
                pending.push_back(rd);
            end
        end
    end

    // Inputs change just after the rising edge; caller checks land just after the falling edge.
    task automatic applyStimulus(input bit iReq, input logic [9:0] iAddr, input bit fl,
                                 input bit lReq, input logic [10:0] lAddr);
        @(posedge clk);
        #1;
        ifReq   = iReq;
        ifAddr  = iAddr;
        ifFlush = fl;
        lpmReq  = lReq;
        lpmAddr = lAddr;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 10'd0, 0, 0, 11'd0);
    endtask

    task automatic padLatency();
`ifdef FLASH_DO_REG_EN
        idle();
`endif
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        ifReq  = 1'b0;
        lpmReq = 1'b0;
        ifFlush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) flashMem[i] = 16'(i * 40503) ^ 16'h1D2B;
        flashMem[0] = 16'h5B05;
        flashMem[1] = 16'hA2C6;
        flashMem[2] = 16'h5946;
        flashMem[3] = 16'hAC02;

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single fetch, then hold across idle cycles.
        applyStimulus(1, 10'd1, 0, 0, 11'd0);
        checkOutput("s1IfGnt", ifGnt, 1);
        checkOutput("s1MemAddr", memAddr, 1);
        idle();
`ifdef FLASH_DO_REG_EN
        checkOutput("s1Regce", memRegce, 1);
        checkOutput("s1EarlyVld", ifVld, 0);
        idle();
`endif
        checkOutput("s1IfVld", ifVld, 1);
        checkOutput("s1IfData", ifData, 16'hA2C6);
        idle();
        checkOutput("s1IfHoldVld", ifVld, 0);
        checkOutput("s1IfHold", ifData, 16'hA2C6);

        // LPM byte lanes.
        applyStimulus(0, 10'd0, 0, 1, 11'h005);
        checkOutput("s2LpmGnt", lpmGnt, 1);
        checkOutput("s2MemAddr", memAddr, 2);
        idle();
        padLatency();
        checkOutput("s2LpmVldHi", lpmVld, 1);
        checkOutput("s2LpmHi", lpmData, 8'h59);
        applyStimulus(0, 10'd0, 0, 1, 11'h004);
        idle();
        padLatency();
        checkOutput("s2LpmLo", lpmData, 8'h46);

        // Continuous contention from reset alternates LPM, IF, LPM, IF.
        doReset();
        applyStimulus(1, 10'd2, 0, 1, 11'h007);
        checkOutput("s3FirstLpm", lpmGnt, 1);
        checkOutput("s3FirstIf", ifGnt, 0);
        applyStimulus(1, 10'd2, 0, 1, 11'h007);
        checkOutput("s3SecondIf", ifGnt, 1);
        checkOutput("s3SecondLpm", lpmGnt, 0);
        for (int i = 0; i < 6; i++) applyStimulus(1, 10'd2, 0, 1, 11'h007);
        idle();
        idle();
        checkOutput("s3IfStable", ifData, 16'h5946);
        checkOutput("s3LpmStable", lpmData, 8'hAC);

        // Flush squashes the older fetch; the redirect fetch in the flush cycle completes.
        applyStimulus(1, 10'd0, 0, 0, 11'd0);
        applyStimulus(1, 10'd3, 1, 0, 11'd0);
        checkOutput("s4FlushVld", ifVld, 0);
        checkOutput("s4FlushHold", ifData, 16'h5946);
        idle();
        padLatency();
        checkOutput("s4RedirVld", ifVld, 1);
        checkOutput("s4RedirData", ifData, 16'hAC02);

        // Reset right after a grant discards the in-flight read.
        applyStimulus(1, 10'd1, 0, 0, 11'd0);
        checkOutput("s5Rden", memRden, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("s5RstIfVld", ifVld, 0);
        checkOutput("s5RstGnt", ifGnt, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ifReq = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("s5RelIfVld", ifVld, 0);
        checkOutput("s5RelIfData", ifData, 0);
        checkOutput("s5RelLpmData", lpmData, 0);
        idle();
        idle();
        applyStimulus(1, 10'd3, 0, 0, 11'd0);
        idle();
        padLatency();
        checkOutput("s5NewVld", ifVld, 1);
        checkOutput("s5NewData", ifData, 16'hAC02);
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
        $finish;
    end

endmodule
